// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes LANES bytes of a 128-bit state per cycle.
// Optional FWD_SBOX_EN adds a per-state mode input selecting the forward S-box instead.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef FWD_SBOX_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [1:0]   fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // out_valid/out_state stay stable until taken, and in_ready never depends on in_valid.

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row-major tables, entry 0 in the top byte: entry b lives at bits [{~b, 3'b000} +: 8].
  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_lut(input logic [7:0] b);
    return INV_TABLE[{~b, 3'b000} +: 8];
  endfunction

`ifdef FWD_SBOX_EN
  localparam logic [2047:0] FWD_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwd_lut(input logic [7:0] b);
    return FWD_TABLE[{~b, 3'b000} +: 8];
  endfunction

  logic mode_q;
`endif

  localparam int LAST_IDX = 16 - LANES;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   idx_q;
  logic [127:0] data_q;
  logic         last_grp;
  logic [3:0]   pos [LANES];
  logic [7:0]   sub [LANES];

  assign last_grp = (idx_q == 4'(LAST_IDX));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] src;
    assign pos[l] = idx_q + 4'(l);
    assign src    = data_q[{pos[l], 3'b000} +: 8];
`ifdef FWD_SBOX_EN
    assign sub[l] = mode_q ? fwd_lut(src) : inv_lut(src);
`else
    assign sub[l] = inv_lut(src);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
`ifdef FWD_SBOX_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_state;
            idx_q  <= '0;
`ifdef FWD_SBOX_EN
            mode_q <= mode;
`endif
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            data_q[{pos[l], 3'b000} +: 8] <= sub[l];
          end
          // Index parks at 0 after the last group so it never steps past 15.
          idx_q <= last_grp ? 4'd0 : idx_q + 4'(LANES);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_state = data_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: three instances (LANES 4, 1, 16) sharing clock and reset,
// expected states derived from GF(2^8) arithmetic and held in a scoreboard queue.
module tb_inv_sub_bytes_seq;

  localparam int NDUT = 3;
  localparam int NL [NDUT] = '{4, 1, 16};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iv   [NDUT];
  logic         ir   [NDUT];
  logic [127:0] ist  [NDUT];
  logic         ov   [NDUT];
  logic         ordy [NDUT];
  logic [127:0] ost  [NDUT];
  logic [1:0]   fst  [NDUT];
`ifdef FWD_SBOX_EN
  logic         md_s [NDUT];
`endif

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];
  int           n_cmp = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    inv_sub_bytes_seq #(.LANES(g == 0 ? 4 : (g == 1 ? 1 : 16))) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_state  (ist[g]),
`ifdef FWD_SBOX_EN
      .mode      (md_s[g]),
`endif
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_state (ost[g]),
      .fsm_state (fst[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] v;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      if (x != 0) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
        end
      end
      s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] st, input bit fwd);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = fwd ? fwd_tab[st[8*i +: 8]] : inv_tab[st[8*i +: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  // Returns at the first negedge after the accept edge.
  task automatic do_accept(input int d, input logic [127:0] st, input bit md, output bit ok);
    ok = 1'b0;
    iv[d]  = 1'b1;
    ist[d] = st;
`ifdef FWD_SBOX_EN
    md_s[d] = md;
`endif
    for (int k = 0; k < 50; k++) begin
      if (ir[d]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  // lat = rising edges after the accept edge at which out_valid is first seen; -1 on timeout.
  task automatic wait_out(input int d, output int lat, output logic [127:0] data);
    lat  = -1;
    data = '0;
    for (int k = 0; k <= 40; k++) begin
      if (ov[d]) begin
        lat  = k;
        data = ost[d];
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      iv[d] = 1'b0; ist[d] = '0; ordy[d] = 1'b1;
`ifdef FWD_SBOX_EN
      md_s[d] = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_cmp++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready dut%0d got %b want 1", d, ir[d]); end
      n_cmp++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, ov[d]); end
      n_cmp++; if (fst[d] !== 2'd0) begin n_fail++; $display("FAIL reset_state dut%0d got %0d want 0", d, fst[d]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lanes4_zero();
    bit ok; int lat; logic [127:0] data; logic [127:0] exp;
    do_accept(0, '0, 1'b0, ok);
    exp_q.push_back({16{8'h52}});
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL l4_accept got timeout want accept"); end
    wait_out(0, lat, data);
    exp = exp_q.pop_front();
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL l4_latency got %0d want 4", lat); end
    n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL l4_zero_data got %h want %h", data, exp); end
    n_cmp++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL l4_in_ready_done got %b want 0", ir[0]); end
    @(negedge clk);
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL l4_valid_fall got %b want 0", ov[0]); end
    n_cmp++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL l4_idle_ready got %b want 1", ir[0]); end
  endtask

  task automatic test_lanes1();
    logic [127:0] st [2];
    logic [127:0] ex [2];
    bit ok; int lat; logic [127:0] data; logic [127:0] exp;
    st[0] = {16{8'h63}};  ex[0] = '0;
    st[1] = 128'h01;      ex[1] = {{15{8'h52}}, 8'h09};
    for (int t = 0; t < 2; t++) begin
      do_accept(1, st[t], 1'b0, ok);
      exp_q.push_back(ex[t]);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL l1_accept%0d got timeout want accept", t); end
      wait_out(1, lat, data);
      exp = exp_q.pop_front();
      n_cmp++; if (lat != 16) begin n_fail++; $display("FAIL l1_latency%0d got %0d want 16", t, lat); end
      n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL l1_data%0d got %h want %h", t, data, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    bit ok; int lat; logic [127:0] data; logic [127:0] exp; logic [127:0] st;
    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 3; t++) begin
        st = rand_state();
        do_accept(d, st, 1'b0, ok);
        exp_q.push_back(model(st, 1'b0));
        wait_out(d, lat, data);
        exp = exp_q.pop_front();
        n_cmp++; if (lat != 16 / NL[d]) begin n_fail++; $display("FAIL rnd_latency dut%0d got %0d want %0d", d, lat, 16 / NL[d]); end
        n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL rnd_data dut%0d got %h want %h", d, data, exp); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [127:0] data; logic [127:0] exp; logic [127:0] st;
    ordy[2] = 1'b0;
    st = rand_state();
    do_accept(2, st, 1'b0, ok);
    exp_q.push_back(model(st, 1'b0));
    wait_out(2, lat, data);
    exp = exp_q.pop_front();
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL bp_latency got %0d want 1", lat); end
    n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL bp_data got %h want %h", data, exp); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (ov[2] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got %b want 1", c, ov[2]); end
      n_cmp++; if (ost[2] !== exp) begin n_fail++; $display("FAIL bp_hold_data c%0d got %h want %h", c, ost[2], exp); end
      n_cmp++; if (ir[2] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready c%0d got %b want 0", c, ir[2]); end
    end
    ordy[2] = 1'b1;
    @(negedge clk);
    n_cmp++; if (ov[2] !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", ov[2]); end
    n_cmp++; if (ir[2] !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", ir[2]); end
    st = rand_state();
    do_accept(2, st, 1'b0, ok);
    exp_q.push_back(model(st, 1'b0));
    n_cmp++; if (fst[2] !== 2'd1) begin n_fail++; $display("FAIL bp_next_accept got state %0d want 1", fst[2]); end
    wait_out(2, lat, data);
    exp = exp_q.pop_front();
    n_cmp++; if (data !== exp || lat != 1) begin n_fail++; $display("FAIL bp_next_data got %h lat %0d want %h lat 1", data, lat, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [127:0] data; logic [127:0] exp; logic [127:0] st;
    do_accept(0, rand_state(), 1'b0, ok);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", ir[0]); end
    n_cmp++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got %b want 0", ov[0]); end
    n_cmp++; if (fst[0] !== 2'd0) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", fst[0]); end
    rst_n = 1'b1;
    st = rand_state();
    do_accept(0, st, 1'b0, ok);
    exp_q.push_back(model(st, 1'b0));
    n_cmp++; if (fst[0] !== 2'd1) begin n_fail++; $display("FAIL rstmid_first_accept got state %0d want 1", fst[0]); end
    wait_out(0, lat, data);
    exp = exp_q.pop_front();
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL rstmid_latency got %0d want 4", lat); end
    n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL rstmid_data got %h want %h", data, exp); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [127:0] st [3];
    for (int i = 0; i < 3; i++) st[i] = rand_state();
    st[1][7:0] = st[0][7:0] + 8'h01;
    ordy[0] = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          iv[0]  = 1'b1;
          ist[0] = st[i];
          exp_q.push_back(model(st[i], 1'b0));
          for (int k = 0; k < 50; k++) begin
            if (ir[0]) break;
            @(negedge clk);
          end
          @(negedge clk);
        end
        iv[0] = 1'b0;
      end
      begin
        int n = 0;
        int got = 0;
        int t_prev = 0;
        bit prev = 1'b0;
        logic [127:0] exp;
        while (got < 3 && n < 80) begin
          @(negedge clk);
          n++;
          if (ov[0] && !prev) begin
            exp = exp_q.pop_front();
            n_cmp++; if (ost[0] !== exp) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", got, ost[0], exp); end
            if (got > 0) begin
              n_cmp++; if (n - t_prev != 6) begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 6", got, n - t_prev); end
            end
            t_prev = n;
            got++;
          end
          prev = ov[0];
        end
        n_cmp++; if (got != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", got); end
      end
    join
    @(negedge clk);
  endtask

`ifdef FWD_SBOX_EN
  task automatic test_mode();
    bit ok; int lat; logic [127:0] data; logic [127:0] exp; logic [127:0] st;
    for (int t = 0; t < 3; t++) begin
      st = (t == 2) ? rand_state() : '0;
      do_accept(0, st, (t != 1), ok);
      exp_q.push_back(t == 0 ? {16{8'h63}} : (t == 1 ? {16{8'h52}} : model(st, 1'b1)));
      wait_out(0, lat, data);
      exp = exp_q.pop_front();
      n_cmp++; if (data !== exp) begin n_fail++; $display("FAIL mode_data%0d got %h want %h", t, data, exp); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tables();
    @(negedge clk);
    test_reset();
    test_lanes4_zero();
    test_lanes1();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef FWD_SBOX_EN
    test_mode();
`endif
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 SHALL provide parameter LANES, default 4, meaning the number of bytes substituted per cycle; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL provide port in_valid, input, 1 bit: in_state is valid.
REQ-005 SHALL provide port in_ready, output, 1 bit: the block accepts a new state.
REQ-006 SHALL provide port in_state, input, 128 bits: AES state; byte i = in_state[8i+7:8i].
REQ-007 SHALL provide port out_valid, output, 1 bit: out_state holds a result.
REQ-008 SHALL provide port out_ready, input, 1 bit: the consumer takes the result.
REQ-009 SHALL provide port out_state, output, 128 bits: the substituted state, with the same byte order as in_state.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE, in_ready=1; when in_valid=1, SHALL capture in_state into an internal 128-bit register, clear the byte index to 0 and go to BUSY.
REQ-012 In BUSY, each cycle SHALL replace bytes idx..idx+LANES-1 with their FIPS-197 inverse S-box value, then set idx = idx + LANES.
REQ-013 When idx+LANES = 16 in BUSY, SHALL complete that last group and go to DONE; BUSY therefore lasts exactly 16/LANES cycles.
REQ-014 In DONE, out_valid=1 and out_state SHALL hold stable until out_ready=1; on out_ready=1 SHALL go to IDLE.
REQ-015 Latency: with out_ready held high, out_valid SHALL rise 16/LANES cycles after the accept edge and fall one cycle later.
REQ-016 in_ready SHALL be 0 in BUSY and DONE; in_valid is ignored there, and no new state is accepted in the same cycle as a DONE->IDLE transition.
REQ-017 out_valid SHALL be 0 in IDLE and BUSY; out_state is don't-care except in DONE.
REQ-018 The byte index SHALL be log2(16) = 4 bits wide; no wrap-around beyond 15 SHALL occur.
REQ-019 The substitution table SHALL be a combinational 256-entry lookup, instantiated LANES times.
REQ-020 Any LANES value outside {1,2,4,8,16} SHALL be a compile-time error.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE, idx=0, in_ready=1, out_valid=0 and the data register to 0, overriding any other event in that cycle.
REQ-022 Reset asserted in BUSY or DONE SHALL abandon the current state with no output produced.
REQ-023 After rst_n returns to 1, the first accept SHALL be possible on the next edge.

Configuration
REQ-024 The macro is FWD_SBOX_EN.
REQ-025 When FWD_SBOX_EN is defined, the block SHALL add an input port mode, 1 bit, sampled at accept; mode=1 SHALL select the forward S-box and mode=0 the inverse S-box for that whole state.
REQ-026 When FWD_SBOX_EN is undefined, there SHALL be no mode port, only the inverse table SHALL be present, and behaviour SHALL be inverse-only.

Verification
REQ-027 LANES=4, in_state=0 -> out_state = 16 bytes of 0x52; out_valid rises exactly 4 cycles after the accept edge.
REQ-028 LANES=1, in_state = all bytes 0x63 -> all bytes 0x00 after 16 BUSY cycles; byte i = 0x01 at i=0 only -> byte0 = 0x09, all other bytes 0x52.
REQ-029 LANES=16, out_ready held 0 for 5 cycles -> out_valid stays 1 and out_state stays stable; in_ready stays 0; after out_ready=1 the next state is accepted the following cycle.
REQ-030 rst_n=0 during the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, and no spurious output.
REQ-031 FWD_SBOX_EN defined, mode=1, in_state=0 -> all bytes 0x63; mode=0 with the same input -> all bytes 0x52.
REQ-032 Back-to-back: in_valid held 1 with 3 distinct states and out_ready=1 -> 3 results in order, each separated by 16/LANES+2 cycles.
